// File: rtl/car_switch_encoder.sv
// car_switch_encoder
// Producer side of the lamp command interface. Four raw dashboard switches
// are synchronised, debounced and encoded into one mode. Every mode change
// holds all command lines low for GAP_CYCLES before the new command appears.
// Optional feature macro: BRAKE_PRIORITY_EN (brake wins over other inputs
// instead of producing CONFLICT).
module car_switch_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int GAP_CYCLES      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       swL,
  input  logic       swR,
  input  logic       swBrake,
  input  logic       swDoor,
  output logic       cmdL,
  output logic       cmdR,
  output logic       cmdBrake,
  output logic       cmdDoor,
  output logic [2:0] mode,
  output logic       mode_strobe,
  output logic       conflict
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [GW-1:0] GAP_ZERO = GW'(0);

  localparam logic [2:0] MODE_IDLE     = 3'd0;
  localparam logic [2:0] MODE_LEFT     = 3'd1;
  localparam logic [2:0] MODE_RIGHT    = 3'd2;
  localparam logic [2:0] MODE_BRAKE    = 3'd3;
  localparam logic [2:0] MODE_DOOR     = 3'd4;
  localparam logic [2:0] MODE_CONFLICT = 3'd5;

  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  // One-hot lamp command for a mode; IDLE and CONFLICT drive nothing.
  function automatic logic [3:0] mode_to_cmd(input logic [2:0] m);
    logic [3:0] c;
    case (m)
      MODE_LEFT:  c = 4'b0001;
      MODE_RIGHT: c = 4'b0010;
      MODE_BRAKE: c = 4'b0100;
      MODE_DOOR:  c = 4'b1000;
      default:    c = 4'b0000;
    endcase
    return c;
  endfunction

  // Bit order everywhere: {door, brake, right, left}.
  logic [3:0]         raw_s;
  logic [3:0]         sync1_q;
  logic [3:0]         sync2_q;
  logic [3:0]         stable_q;
  logic [3:0]         stable_d;
  logic [3:0][CW-1:0] cnt_q;
  logic [3:0][CW-1:0] cnt_d;
  logic [2:0]         target_s;

  state_t             state_q;
  logic [2:0]         mode_q;
  logic [2:0]         pend_q;
  logic [3:0]         cmd_q;
  logic               strobe_q;
  logic               conflict_q;
  logic [GW-1:0]      gap_cnt_q;

  assign raw_s = {swDoor, swBrake, swR, swL};

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: a disagreement must persist DEBOUNCE_CYCLES evaluations.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] != DB_LAST) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = CNT_ZERO;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 4'b0000;
      cnt_q    <= {(4*CW){1'b0}};
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Encode the stable switch vector into the requested mode.
  always_comb begin
    target_s = MODE_CONFLICT;
    case (stable_q)
      4'b0000: target_s = MODE_IDLE;
      4'b0001: target_s = MODE_LEFT;
      4'b0010: target_s = MODE_RIGHT;
      4'b0100: target_s = MODE_BRAKE;
      4'b1000: target_s = MODE_DOOR;
      default: begin
`ifdef BRAKE_PRIORITY_EN
        if (stable_q[2]) begin
          target_s = MODE_BRAKE;
        end else begin
          target_s = MODE_CONFLICT;
        end
`else
        target_s = MODE_CONFLICT;
`endif
      end
    endcase
  end

  // Mode FSM: blank all commands for GAP_CYCLES, then apply the settled target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      mode_q     <= MODE_IDLE;
      pend_q     <= MODE_IDLE;
      cmd_q      <= 4'b0000;
      strobe_q   <= 1'b0;
      conflict_q <= 1'b0;
      gap_cnt_q  <= GAP_ZERO;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        ST_HOLD: begin
          if (target_s != mode_q) begin
            state_q   <= ST_GAP;
            cmd_q     <= 4'b0000;
            gap_cnt_q <= GAP_ZERO;
            pend_q    <= target_s;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        ST_GAP: begin
          if (target_s != pend_q) begin
            // Target moved during the gap: restart the gap for the latest one.
            pend_q    <= target_s;
            gap_cnt_q <= GAP_ZERO;
          end else if (gap_cnt_q == GAP_LAST) begin
            mode_q     <= pend_q;
            cmd_q      <= mode_to_cmd(pend_q);
            conflict_q <= (pend_q == MODE_CONFLICT);
            // A target that bounced back to the current mode restores the
            // command but is not a new mode, so no strobe.
            strobe_q   <= (pend_q != mode_q);
            state_q    <= ST_HOLD;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_ONE;
          end
        end
        default: begin
          state_q <= ST_HOLD;
          cmd_q   <= 4'b0000;
        end
      endcase
    end
  end

  assign cmdL        = cmd_q[0];
  assign cmdR        = cmd_q[1];
  assign cmdBrake    = cmd_q[2];
  assign cmdDoor     = cmd_q[3];
  assign mode        = mode_q;
  assign mode_strobe = strobe_q;
  assign conflict    = conflict_q;

endmodule
